// File: rtl/plab5_mcore_mem_req_net_arb_pkg.sv
// Shared types and constants for the domain-aware memory request network arbiter.
// State encoding, domain tags and the one-hot grant helper.
package plab5_mcore_mem_req_net_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FULL  = 2'd1,
    ST_SCRUB = 2'd2
  } state_t;

  localparam logic DOM_NORMAL = 1'b0;
  localparam logic DOM_SECURE = 1'b1;

  localparam int P_CTRL_NBITS = 76;
  localparam int P_DATA_NBITS = 32;

  function automatic logic [1:0] idx2gnt(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_req_net_arb_if.sv
// Two split-message request ports, one shared network injection port, and the grant.
// slave: the arbiter; master: the requesters plus the network side.
interface plab5_mcore_mem_req_net_arb_if #(
  parameter int p_ctrl_nbits = 76,
  parameter int p_data_nbits = 32
);
  logic                    in0_val;
  logic                    in0_rdy;
  logic                    in0_domain;
  logic [p_ctrl_nbits-1:0] in0_msg_control;
  logic [p_data_nbits-1:0] in0_msg_data;

  logic                    in1_val;
  logic                    in1_rdy;
  logic                    in1_domain;
  logic [p_ctrl_nbits-1:0] in1_msg_control;
  logic [p_data_nbits-1:0] in1_msg_data;

  logic                    out_val;
  logic                    out_rdy;
  logic                    out_domain;
  logic [p_ctrl_nbits-1:0] out_msg_control;
  logic [p_data_nbits-1:0] out_msg_data;

  logic [1:0]              grant;

  modport slave (
    input  in0_val, in0_domain, in0_msg_control, in0_msg_data,
    input  in1_val, in1_domain, in1_msg_control, in1_msg_data,
    input  out_rdy,
    output in0_rdy, in1_rdy,
    output out_val, out_domain, out_msg_control, out_msg_data,
    output grant
  );

  modport master (
    output in0_val, in0_domain, in0_msg_control, in0_msg_data,
    output in1_val, in1_domain, in1_msg_control, in1_msg_data,
    output out_rdy,
    input  in0_rdy, in1_rdy,
    input  out_val, out_domain, out_msg_control, out_msg_data,
    input  grant
  );

endinterface

// File: rtl/plab5_mcore_rr_arb2.sv
// Two-requester round-robin arbiter; combinational grant, pointer flips when the
// priority holder is served (en). lock forces grant to lock_gnt.
module plab5_mcore_rr_arb2
  import plab5_mcore_mem_req_net_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       lock,
  input  logic [1:0] lock_gnt,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (lock)
      gnt = lock_gnt;
    else if (req[ptr_q])
      gnt = idx2gnt(ptr_q);
    else if (req[!ptr_q])
      gnt = idx2gnt(!ptr_q);
  end

  // Only a win by the priority holder passes priority to the other side.
  always_comb begin
    ptr_d = ptr_q;
    if (en && gnt[ptr_q])
      ptr_d = !ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/plab5_mcore_mem_req_net_arb.sv
// Shares one request injection port between two requesters; winner registered, 1-cycle latency.
// in_rdy only in a capture cycle; a domain change zeroes the data path for p_scrub_cycles bubbles.
module plab5_mcore_mem_req_net_arb
  import plab5_mcore_mem_req_net_arb_pkg::*;
#(
  parameter int p_ctrl_nbits   = P_CTRL_NBITS,
  parameter int p_data_nbits   = P_DATA_NBITS,
  parameter int p_scrub_cycles = 1
)(
  input logic                         clk,
  input logic                         reset,
  plab5_mcore_mem_req_net_arb_if.slave bus
);

  localparam int CNT_W = $clog2(p_scrub_cycles + 1);

  state_t                  state_q, state_d;
  logic                    out_val_q, out_val_d;
  logic                    out_dom_q, out_dom_d;
  logic [p_ctrl_nbits-1:0] out_ctrl_q, out_ctrl_d;
  logic [p_data_nbits-1:0] out_data_q, out_data_d;
  logic                    last_dom_q, last_dom_d;
  logic                    pend_dom_q, pend_dom_d;
  logic                    lock_q, lock_d;
  logic                    lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [1:0] req, gnt, lock_gnt;
  logic       lock_act, win_vld, win_idx, win_dom;
  logic       cap_opp, capture, mismatch;

  assign req      = {bus.in1_val, bus.in0_val};
  assign lock_gnt = idx2gnt(lock_idx_q);
  // The lock holds through SCRUB and into IDLE until the locked requester is served or withdraws.
  assign lock_act = lock_q && ((state_q == ST_SCRUB) || req[lock_idx_q]);

  plab5_mcore_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .en       (capture),
    .lock     (lock_act),
    .lock_gnt (lock_gnt),
    .gnt      (gnt)
  );

  assign win_vld  = |gnt;
  assign win_idx  = gnt[1];
  assign win_dom  = win_idx ? bus.in1_domain : bus.in0_domain;
  assign cap_opp  = (state_q == ST_IDLE) || ((state_q == ST_FULL) && bus.out_rdy);
  assign capture  = cap_opp && win_vld && (win_dom == last_dom_q);
  assign mismatch = cap_opp && win_vld && (win_dom != last_dom_q);

  assign bus.in0_rdy         = capture && gnt[0];
  assign bus.in1_rdy         = capture && gnt[1];
  assign bus.grant           = gnt;
  assign bus.out_val         = out_val_q;
  assign bus.out_domain      = out_dom_q;
  assign bus.out_msg_control = out_ctrl_q;
  assign bus.out_msg_data    = out_data_q;

  always_comb begin
    state_d    = state_q;
    out_val_d  = out_val_q;
    out_dom_d  = out_dom_q;
    out_ctrl_d = out_ctrl_q;
    out_data_d = out_data_q;
    last_dom_d = last_dom_q;
    pend_dom_d = pend_dom_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE, ST_FULL: begin
        if (cap_opp) begin
          if (capture) begin
            state_d    = ST_FULL;
            out_val_d  = 1'b1;
            out_dom_d  = win_dom;
            out_ctrl_d = win_idx ? bus.in1_msg_control : bus.in0_msg_control;
            out_data_d = win_idx ? bus.in1_msg_data    : bus.in0_msg_data;
            lock_d     = 1'b0;
          end else if (mismatch) begin
            state_d    = ST_SCRUB;
            out_val_d  = 1'b0;
            out_ctrl_d = '0;
            out_data_d = '0;
            pend_dom_d = win_dom;
            lock_d     = 1'b1;
            lock_idx_d = win_idx;
            cnt_d      = CNT_W'(p_scrub_cycles - 1);
          end else begin
            state_d   = ST_IDLE;
            out_val_d = 1'b0;
            lock_d    = 1'b0;
          end
        end
      end
      ST_SCRUB: begin
        if (cnt_q == '0) begin
          state_d    = ST_IDLE;
          last_dom_d = pend_dom_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      out_val_q  <= 1'b0;
      out_dom_q  <= DOM_NORMAL;
      out_ctrl_q <= '0;
      out_data_q <= '0;
      last_dom_q <= DOM_NORMAL;
      pend_dom_q <= DOM_NORMAL;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_val_q  <= out_val_d;
      out_dom_q  <= out_dom_d;
      out_ctrl_q <= out_ctrl_d;
      out_data_q <= out_data_d;
      last_dom_q <= last_dom_d;
      pend_dom_q <= pend_dom_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_req_net_arb.sv
// Directed bench: dut has one scrub cycle, dut3 has three; both share clock and reset.
module tb_plab5_mcore_mem_req_net_arb;
  import plab5_mcore_mem_req_net_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  plab5_mcore_mem_req_net_arb_if #(.p_ctrl_nbits(76), .p_data_nbits(32)) bus  ();
  plab5_mcore_mem_req_net_arb_if #(.p_ctrl_nbits(76), .p_data_nbits(32)) bus3 ();

  plab5_mcore_mem_req_net_arb #(.p_ctrl_nbits(76), .p_data_nbits(32), .p_scrub_cycles(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  plab5_mcore_mem_req_net_arb #(.p_ctrl_nbits(76), .p_data_nbits(32), .p_scrub_cycles(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.in0_val = 0; bus.in0_domain = 0; bus.in0_msg_control = '0; bus.in0_msg_data = '0;
    bus.in1_val = 0; bus.in1_domain = 0; bus.in1_msg_control = '0; bus.in1_msg_data = '0;
    bus.out_rdy = 1;
    bus3.in0_val = 0; bus3.in0_domain = 0; bus3.in0_msg_control = '0; bus3.in0_msg_data = '0;
    bus3.in1_val = 0; bus3.in1_domain = 0; bus3.in1_msg_control = '0; bus3.in1_msg_data = '0;
    bus3.out_rdy = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_chk++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL rst_out_val got=%b exp=0", bus.out_val); end
    n_chk++; if (bus.out_msg_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data got=%h exp=0", bus.out_msg_data); end
    n_chk++; if (bus.out_msg_control !== 76'h0) begin n_fail++; $display("FAIL rst_out_ctrl got=%h exp=0", bus.out_msg_control); end
    n_chk++; if (bus.out_domain !== 1'b0) begin n_fail++; $display("FAIL rst_out_dom got=%b exp=0", bus.out_domain); end
    n_chk++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant got=%b exp=00", bus.grant); end
    n_chk++; if (bus3.out_val !== 1'b0) begin n_fail++; $display("FAIL rst3_out_val got=%b exp=0", bus3.out_val); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.in0_val = 1; bus.in0_domain = DOM_NORMAL; bus.in0_msg_data = 32'hdead_beef; bus.in0_msg_control = 76'hA5;
    #1;
    n_chk++; if (bus.in0_rdy !== 1'b1) begin n_fail++; $display("FAIL single_in0_rdy got=%b exp=1", bus.in0_rdy); end
    n_chk++; if (bus.in1_rdy !== 1'b0) begin n_fail++; $display("FAIL single_in1_rdy got=%b exp=0", bus.in1_rdy); end
    n_chk++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL single_grant got=%b exp=01", bus.grant); end
    step();
    bus.in0_val = 0;
    n_chk++; if (bus.out_val !== 1'b1) begin n_fail++; $display("FAIL single_out_val got=%b exp=1", bus.out_val); end
    n_chk++; if (bus.out_msg_data !== 32'hdead_beef) begin n_fail++; $display("FAIL single_out_data got=%h exp=deadbeef", bus.out_msg_data); end
    n_chk++; if (bus.out_msg_control !== 76'hA5) begin n_fail++; $display("FAIL single_out_ctrl got=%h exp=a5", bus.out_msg_control); end
    step();
    n_chk++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", bus.out_val); end
  endtask

  task automatic test_alternate();
    int i0 = 0;
    int i1 = 0;
    logic [1:0]  exp_g;
    logic [31:0] exp_d = '0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      bus.in0_val = (i0 < 4); bus.in0_msg_data = 32'h1000_0000 + 32'(i0);
      bus.in1_val = (i1 < 4); bus.in1_msg_data = 32'h2000_0000 + 32'(i1);
      #1;
      if (c > 0) begin
        n_chk++; if (bus.out_val !== 1'b1) begin n_fail++; $display("FAIL alt_out_val c=%0d got=%b exp=1", c, bus.out_val); end
        n_chk++; if (bus.out_msg_data !== exp_d) begin n_fail++; $display("FAIL alt_out_data c=%0d got=%h exp=%h", c, bus.out_msg_data, exp_d); end
      end
      if (c < 8) begin
        exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
        n_chk++; if (bus.grant !== exp_g) begin n_fail++; $display("FAIL alt_grant c=%0d got=%b exp=%b", c, bus.grant, exp_g); end
        n_chk++; if ({bus.in1_rdy, bus.in0_rdy} !== exp_g) begin n_fail++; $display("FAIL alt_rdy c=%0d got=%b exp=%b", c, {bus.in1_rdy, bus.in0_rdy}, exp_g); end
        if (exp_g[0]) begin exp_d = 32'h1000_0000 + 32'(i0); i0++; end
        else          begin exp_d = 32'h2000_0000 + 32'(i1); i1++; end
      end
      step();
    end
  endtask

  task automatic test_domain_switch();
    do_reset();
    bus.in0_val = 1; bus.in0_domain = DOM_NORMAL; bus.in0_msg_data = 32'haaaa_0001;
    #1;
    n_chk++; if (bus.in0_rdy !== 1'b1) begin n_fail++; $display("FAIL sw_in0_rdy got=%b exp=1", bus.in0_rdy); end
    step();
    bus.in0_val = 0;
    bus.in1_val = 1; bus.in1_domain = DOM_SECURE; bus.in1_msg_data = 32'hbbbb_0002; bus.in1_msg_control = 76'h77;
    #1;
    n_chk++; if (bus.out_msg_data !== 32'haaaa_0001) begin n_fail++; $display("FAIL sw_first_data got=%h exp=aaaa0001", bus.out_msg_data); end
    n_chk++; if (bus.in1_rdy !== 1'b0) begin n_fail++; $display("FAIL sw_mismatch_rdy got=%b exp=0", bus.in1_rdy); end
    step();
    n_chk++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL sw_scrub_val got=%b exp=0", bus.out_val); end
    n_chk++; if (bus.out_msg_data !== 32'h0) begin n_fail++; $display("FAIL sw_scrub_data got=%h exp=0", bus.out_msg_data); end
    n_chk++; if (bus.out_msg_control !== 76'h0) begin n_fail++; $display("FAIL sw_scrub_ctrl got=%h exp=0", bus.out_msg_control); end
    n_chk++; if (bus.grant !== 2'b10) begin n_fail++; $display("FAIL sw_scrub_grant got=%b exp=10", bus.grant); end
    n_chk++; if (bus.in1_rdy !== 1'b0) begin n_fail++; $display("FAIL sw_scrub_rdy got=%b exp=0", bus.in1_rdy); end
    step();
    n_chk++; if (bus.in1_rdy !== 1'b1) begin n_fail++; $display("FAIL sw_capture_rdy got=%b exp=1", bus.in1_rdy); end
    n_chk++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL sw_idle_val got=%b exp=0", bus.out_val); end
    step();
    bus.in1_val = 0;
    n_chk++; if (bus.out_val !== 1'b1) begin n_fail++; $display("FAIL sw_second_val got=%b exp=1", bus.out_val); end
    n_chk++; if (bus.out_msg_data !== 32'hbbbb_0002) begin n_fail++; $display("FAIL sw_second_data got=%h exp=bbbb0002", bus.out_msg_data); end
    n_chk++; if (bus.out_domain !== 1'b1) begin n_fail++; $display("FAIL sw_second_dom got=%b exp=1", bus.out_domain); end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.in1_domain = DOM_NORMAL;
    bus.in0_val = 1; bus.in0_domain = DOM_NORMAL; bus.in0_msg_data = 32'h1111_1111;
    step();
    bus.in0_val = 0;
    bus.out_rdy = 0;
    bus.in1_val = 1; bus.in1_msg_data = 32'h2222_2222;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_chk++; if (bus.out_val !== 1'b1) begin n_fail++; $display("FAIL bp_val k=%0d got=%b exp=1", k, bus.out_val); end
      n_chk++; if (bus.out_msg_data !== 32'h1111_1111) begin n_fail++; $display("FAIL bp_data k=%0d got=%h exp=11111111", k, bus.out_msg_data); end
      n_chk++; if ({bus.in1_rdy, bus.in0_rdy} !== 2'b00) begin n_fail++; $display("FAIL bp_rdy k=%0d got=%b exp=00", k, {bus.in1_rdy, bus.in0_rdy}); end
      step();
    end
    bus.out_rdy = 1;
    #1;
    n_chk++; if (bus.in1_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy got=%b exp=1", bus.in1_rdy); end
    step();
    bus.in1_val = 0;
    n_chk++; if (bus.out_msg_data !== 32'h2222_2222) begin n_fail++; $display("FAIL bp_next_data got=%h exp=22222222", bus.out_msg_data); end
    step();
  endtask

  task automatic test_reset_mid_full();
    do_reset();
    bus.in0_val = 1; bus.in0_domain = DOM_NORMAL; bus.in0_msg_data = 32'h3333_3333; bus.in0_msg_control = 76'h5;
    step();
    bus.in0_val = 0;
    bus.out_rdy = 0;
    #1;
    n_chk++; if (bus.out_val !== 1'b1) begin n_fail++; $display("FAIL midfull_pre_val got=%b exp=1", bus.out_val); end
    #1 reset = 1'b1;
    #1;
    n_chk++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL midfull_async_val got=%b exp=0", bus.out_val); end
    n_chk++; if (bus.out_msg_data !== 32'h0) begin n_fail++; $display("FAIL midfull_async_data got=%h exp=0", bus.out_msg_data); end
    n_chk++; if (bus.out_msg_control !== 76'h0) begin n_fail++; $display("FAIL midfull_async_ctrl got=%h exp=0", bus.out_msg_control); end
    step();
    reset = 1'b0;
    bus.out_rdy = 1;
  endtask

  task automatic test_reset_mid_scrub();
    do_reset();
    bus3.in1_val = 1; bus3.in1_domain = DOM_SECURE; bus3.in1_msg_data = 32'h4444_4444;
    #1;
    n_chk++; if (bus3.in1_rdy !== 1'b0) begin n_fail++; $display("FAIL ms_mismatch_rdy got=%b exp=0", bus3.in1_rdy); end
    step();
    bus3.in1_val = 0;
    #1;
    n_chk++; if (bus3.grant !== 2'b10) begin n_fail++; $display("FAIL ms_locked_grant got=%b exp=10", bus3.grant); end
    n_chk++; if (bus3.out_val !== 1'b0) begin n_fail++; $display("FAIL ms_scrub_val got=%b exp=0", bus3.out_val); end
    step();
    reset = 1'b1;
    #1;
    n_chk++; if (bus3.grant !== 2'b00) begin n_fail++; $display("FAIL ms_async_grant got=%b exp=00", bus3.grant); end
    n_chk++; if (bus3.out_msg_data !== 32'h0) begin n_fail++; $display("FAIL ms_async_data got=%h exp=0", bus3.out_msg_data); end
    step();
    reset = 1'b0;
    bus3.in0_val = 1; bus3.in0_domain = DOM_NORMAL; bus3.in0_msg_data = 32'h5555_5555;
    #1;
    n_chk++; if (bus3.in0_rdy !== 1'b1) begin n_fail++; $display("FAIL ms_post_rdy got=%b exp=1", bus3.in0_rdy); end
    step();
    bus3.in0_val = 0;
    n_chk++; if (bus3.out_msg_data !== 32'h5555_5555) begin n_fail++; $display("FAIL ms_post_data got=%h exp=55555555", bus3.out_msg_data); end
    step();
  endtask

  // Runs right after test_reset_mid_scrub: its in0 capture left priority with in1, last domain 0.
  task automatic test_domain_order();
    bus3.in0_val = 1; bus3.in0_domain = DOM_SECURE; bus3.in0_msg_data = 32'h0a0a_0a0a;
    bus3.in1_val = 1; bus3.in1_domain = DOM_NORMAL; bus3.in1_msg_data = 32'h1b1b_1b1b;
    #1;
    n_chk++; if (bus3.grant !== 2'b10) begin n_fail++; $display("FAIL ord_first_grant got=%b exp=10", bus3.grant); end
    n_chk++; if ({bus3.in1_rdy, bus3.in0_rdy} !== 2'b10) begin n_fail++; $display("FAIL ord_first_rdy got=%b exp=10", {bus3.in1_rdy, bus3.in0_rdy}); end
    step();
    bus3.in1_val = 0;
    #1;
    n_chk++; if (bus3.out_msg_data !== 32'h1b1b_1b1b) begin n_fail++; $display("FAIL ord_first_data got=%h exp=1b1b1b1b", bus3.out_msg_data); end
    n_chk++; if (bus3.in0_rdy !== 1'b0) begin n_fail++; $display("FAIL ord_mismatch_rdy got=%b exp=0", bus3.in0_rdy); end
    step();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (bus3.out_val !== 1'b0) begin n_fail++; $display("FAIL ord_scrub_val k=%0d got=%b exp=0", k, bus3.out_val); end
      n_chk++; if (bus3.in0_rdy !== 1'b0) begin n_fail++; $display("FAIL ord_scrub_rdy k=%0d got=%b exp=0", k, bus3.in0_rdy); end
      n_chk++; if (bus3.grant !== 2'b01) begin n_fail++; $display("FAIL ord_scrub_grant k=%0d got=%b exp=01", k, bus3.grant); end
      step();
    end
    n_chk++; if (bus3.in0_rdy !== 1'b1) begin n_fail++; $display("FAIL ord_capture_rdy got=%b exp=1", bus3.in0_rdy); end
    step();
    bus3.in0_val = 0;
    n_chk++; if (bus3.out_val !== 1'b1) begin n_fail++; $display("FAIL ord_second_val got=%b exp=1", bus3.out_val); end
    n_chk++; if (bus3.out_msg_data !== 32'h0a0a_0a0a) begin n_fail++; $display("FAIL ord_second_data got=%h exp=0a0a0a0a", bus3.out_msg_data); end
    n_chk++; if (bus3.out_domain !== 1'b1) begin n_fail++; $display("FAIL ord_second_dom got=%b exp=1", bus3.out_domain); end
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_domain_switch();
    test_backpressure();
    test_reset_mid_full();
    test_reset_mid_scrub();
    test_domain_order();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
